// File: rtl/imem_serial_loader.sv
// imem_serial_loader: packs pad bytes little-endian into 32-bit words and writes them to instruction memory.
// The core is held in reset for the whole load session and released when load_en drops.
module imem_serial_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic                  byte_strobe,
    input  logic [7:0]            byte_in,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  err_partial,
    output logic                  err_overflow
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0]      en_sync, stb_sync;
    logic [SYNC_STAGES-1:0][7:0] byte_sync;
    logic                        en_s, stb_s, stb_prev, strobe_rise;
    logic [7:0]                  byte_s;
    logic [1:0]                  idx;
    logic [ADDR_WIDTH-1:0]       ptr;
    logic                        full;
    logic [23:0]                 lanes;

    assign en_s        = en_sync[SYNC_STAGES-1];
    assign stb_s       = stb_sync[SYNC_STAGES-1];
    assign byte_s      = byte_sync[SYNC_STAGES-1];
    assign strobe_rise = stb_s & ~stb_prev;
    assign imem_we     = state == WRITE;
    assign cpu_hold    = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // session end takes priority over a coincident strobe
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = en_s ? LOAD : IDLE;
            LOAD:    state_nxt = !en_s ? IDLE : (strobe_rise && !full && idx == 2'd3) ? WRITE : LOAD;
            WRITE:   state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_sync      <= '0;
            stb_sync     <= '0;
            byte_sync    <= '0;
            stb_prev     <= 1'b0;
            idx          <= 2'd0;
            ptr          <= '0;
            full         <= 1'b0;
            lanes        <= '0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            en_sync   <= {en_sync[SYNC_STAGES-2:0], load_en};
            stb_sync  <= {stb_sync[SYNC_STAGES-2:0], byte_strobe};
            byte_sync <= {byte_sync[SYNC_STAGES-2:0], byte_in};
            stb_prev  <= stb_s;
            if (state == IDLE && en_s) begin
                idx          <= 2'd0;
                ptr          <= '0;
                full         <= 1'b0;
                words_loaded <= '0;
                err_partial  <= 1'b0;
                err_overflow <= 1'b0;
            end else if (state == LOAD && !en_s) begin
                if (idx != 2'd0) err_partial <= 1'b1;
                idx <= 2'd0;
            end else if (state == LOAD && strobe_rise) begin
                if (full) begin
                    err_overflow <= 1'b1;
                end else begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        imem_addr  <= ptr;
                        imem_wdata <= {byte_s, lanes};
                    end else begin
                        lanes[{idx, 3'b000} +: 8] <= byte_s;
                    end
                end
            end else if (state == WRITE) begin
                words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
                // the last word marks memory full instead of wrapping the pointer
                if (&ptr) full <= 1'b1;
                else      ptr  <= ptr + ADDR_WIDTH'(1);
            end
        end
    end
endmodule
